// File: rtl/systolic_drain.sv
// Collects the N result lanes of the systolic array into per-lane FIFOs and
// serializes them row-major onto one valid/ready stream tagged with (row, col).
module systolic_drain #(
    parameter int D_W        = 8,
    parameter int N          = 3,
    parameter int M          = 6,
    parameter int FIFO_DEPTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*2*D_W-1:0]   m2,
    input  logic [N-1:0]         valid_m2,
    output logic [2*D_W-1:0]     out_data,
    output logic [$clog2(M)-1:0] out_row,
    output logic [$clog2(M)-1:0] out_col,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 tile_done,
    output logic                 matrix_done,
    output logic [N-1:0]         overflow,
    input  logic                 flag_clr
);
    localparam int DW2 = 2 * D_W;
    localparam int RW  = $clog2(M);
    localparam int SW  = (N > 1) ? $clog2(N) : 1;
    localparam int T   = M / N;
    localparam int TW  = (T > 1) ? $clog2(T) : 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   sel_reg;
    logic [RW-1:0]   col_reg;
    logic [TW-1:0]   tile_reg;
    logic            last_pend_reg;
    logic            drain_en;
    logic            load;
    logic [RW-1:0]   row_calc;
    logic [N-1:0]    pop;
    logic [N-1:0]    nonempty;
    logic [N-1:0]    drop;
    logic [N-1:0]    overflow_next;
    logic [DW2-1:0]  head [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DW2-1:0] mem [FIFO_DEPTH];
            logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0]  count_reg;
            logic           accept;

            // A full FIFO still accepts when its head leaves in the same cycle.
            assign accept = valid_m2[gi] && ((count_reg != CW'(FIFO_DEPTH)) || pop[gi]);
            assign drop[gi] = valid_m2[gi] && !accept;
            assign nonempty[gi] = (count_reg != '0);
            assign head[gi] = mem[rd_ptr_reg];
            assign pop[gi] = load && (sel_reg == SW'(gi));
            assign overflow_next[gi] = drop[gi] | (overflow[gi] & ~flag_clr);

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem[wr_ptr_reg] <= m2[gi*DW2 +: DW2];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (accept) begin
                        wr_ptr_reg <= (wr_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= (rd_ptr_reg == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
                    end
                    if (accept && !pop[gi]) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (!accept && pop[gi]) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= '0;
        end else begin
            overflow <= overflow_next;
        end
    end

    // Once the tile's final word sits in the output register, stop popping
    // until it transfers so the next tile's lane-0 words are not taken early.
    assign load = drain_en && !last_pend_reg && (!out_valid || out_ready) && nonempty[sel_reg];
    assign row_calc = RW'(tile_reg) * RW'(N) + RW'(sel_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (nonempty[0]) state_next = DRAIN;
            DRAIN:   if (last_pend_reg && out_valid && out_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drain_en    = 1'b0;
        tile_done   = 1'b0;
        matrix_done = 1'b0;
        case (state_reg)
            DRAIN: drain_en = 1'b1;
            DONE: begin
                tile_done   = 1'b1;
                matrix_done = (tile_reg == TW'(T - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg       <= '0;
            col_reg       <= '0;
            tile_reg      <= '0;
            last_pend_reg <= 1'b0;
        end else begin
            if (load) begin
                if (col_reg == RW'(M - 1)) begin
                    col_reg <= '0;
                    sel_reg <= (sel_reg == SW'(N - 1)) ? '0 : sel_reg + SW'(1);
                    if (sel_reg == SW'(N - 1)) begin
                        last_pend_reg <= 1'b1;
                    end
                end else begin
                    col_reg <= col_reg + RW'(1);
                end
            end
            if (tile_done) begin
                last_pend_reg <= 1'b0;
                tile_reg      <= (tile_reg == TW'(T - 1)) ? '0 : tile_reg + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head[sel_reg];
            out_row   <= row_calc;
            out_col   <= col_reg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
